instruction_fetch_unit: RTL

Fetch stage between the program counter and the TSC memory port. Owns the PC and drives the readM/address request to memory. Captures the returned instruction word on input_ready and holds it with a valid/ack handshake until the control/datapath stage retires it. Replaces the ad-hoc cycle-counter fetch logic with an explicit state machine, jump redirect, instruction count and a request watchdog.

---
 rtl/instruction_fetch_unit_pkg.sv | 20 ++
 rtl/instruction_fetch_unit_if.sv | 47 ++++
 rtl/instruction_fetch_unit_fetch_watchdog.sv | 40 ++++
 rtl/instruction_fetch_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit:
// word/target geometry, fetch FSM encoding and reset PC.
package instruction_fetch_unit_pkg;

    localparam int WORD_SIZE = 16;

    localparam int TGT_LEFT  = 11;
    localparam int TGT_RIGHT = 0;
    localparam int TGT_W     = TGT_LEFT - TGT_RIGHT + 1;

    localparam logic [WORD_SIZE-1:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_RETRY = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch bus: memory request/response plus the held-instruction
// handshake towards the control/datapath stage.
import instruction_fetch_unit_pkg::*;

interface instruction_fetch_unit_if #(
    parameter int W  = WORD_SIZE,
    parameter int TW = TGT_W
);
    logic          readM;
    logic [W-1:0]  address;
    logic [W-1:0]  mem_data;
    logic          input_ready;

    logic [W-1:0]  instruction;
    logic          instr_valid;
    logic          instr_ack;
    logic          jump;
    logic [TW-1:0] j_target;
    logic [W-1:0]  pc_plus1;

    modport master (
        output readM,
        output address,
        input  mem_data,
        input  input_ready,
        output instruction,
        output instr_valid,
        input  instr_ack,
        input  jump,
        input  j_target,
        output pc_plus1
    );

    modport slave (
        input  readM,
        input  address,
        output mem_data,
        output input_ready,
        input  instruction,
        input  instr_valid,
        output instr_ack,
        output jump,
        output j_target,
        input  pc_plus1
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_watchdog.sv
// Request watchdog: counts cycles while enabled and flags the
// last allowed cycle; wraps to zero on expiry.
module fetch_watchdog #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = enable_i && (cnt_q == LAST);

    // next count: clear wins, otherwise count and wrap on expiry
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, requests instruction words from memory
// and holds each one until the consumer retires it.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int WORD_SIZE = instruction_fetch_unit_pkg::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC = RESET_PC_DEF,
    parameter int TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    instruction_fetch_unit_if.master bus,
    output logic [WORD_SIZE-1:0]    num_inst,
    output logic                    fetch_timeout
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] pc_d;
    logic [WORD_SIZE-1:0] instr_q;
    logic [WORD_SIZE-1:0] instr_d;
    logic [WORD_SIZE-1:0] num_q;
    logic [WORD_SIZE-1:0] num_d;
    logic                 valid_q;
    logic                 valid_d;
    logic                 tmo_q;
    logic                 tmo_d;

    logic in_req;
    logic capture;
    logic retire;
    logic timeout_hit;
    logic wd_clear;
    logic wd_expired;

    assign in_req      = (state_q == ST_REQ);
    assign capture     = in_req && bus.input_ready;
    assign retire      = (state_q == ST_VALID) && bus.instr_ack;
    assign timeout_hit = in_req && !bus.input_ready && wd_expired;

    // the count restarts on every fresh request and on a response
    assign wd_clear = !in_req || bus.input_ready;

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (wd_clear),
        .enable_i  (in_req),
        .expired_o (wd_expired)
    );

    // fetch FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // fetch FSM next state; a response beats the watchdog
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_REQ;
            ST_REQ: begin
                if (capture) begin
                    state_d = ST_VALID;
                end else if (wd_expired) begin
                    state_d = ST_RETRY;
                end
            end
            ST_VALID: begin
                if (retire) begin
                    state_d = ST_REQ;
                end
            end
            ST_RETRY: state_d = ST_REQ;
        endcase
    end

    // fetch FSM outputs: request only while in REQ
    always_comb begin
        bus.readM = 1'b0;
        unique case (state_q)
            ST_REQ:   bus.readM = 1'b1;
            ST_IDLE,
            ST_VALID,
            ST_RETRY: bus.readM = 1'b0;
        endcase
    end

    // datapath next state: capture, retire or timeout flag
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        num_d   = num_q;
        valid_d = valid_q;
        tmo_d   = tmo_q;
        unique case (1'b1)
            capture: begin
                instr_d = bus.mem_data;
                valid_d = 1'b1;
            end
            retire: begin
                valid_d = 1'b0;
                num_d   = num_q + 1'b1;
                pc_d    = bus.jump
                        ? {pc_q[WORD_SIZE-1:TGT_LEFT+1], bus.j_target}
                        : pc_q + 1'b1;
            end
            timeout_hit: begin
                tmo_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.address     = pc_q;
    assign bus.pc_plus1    = pc_q + 1'b1;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign num_inst        = num_q;
    assign fetch_timeout   = tmo_q;

endmodule
